irq_flags: RTL and testbench

Interrupt-flag register (IF, 0xFF0F) feeding the CPU interrupt logic. It captures rising-edge requests from the on-chip peripherals (VBlank, STAT, Timer, Serial, Joypad) and holds them as sticky flags. It presents the flags to the CPU interrupt logic on `CPU_IRQ_TRIG`, clears a flag when that logic acknowledges it on `CPU_IRQ_ACK`, and exposes the register to the CPU data bus for reads and writes.

---
 rtl/irq_flags_if.sv | 28 ++
 rtl/irq_flags.sv | 104 ++++++++++
 tb/tb_irq_flags.sv | 195 +++++++++++++++++++
 3 files changed

// File: rtl/irq_flags_if.sv
// Interrupt-flag register bus bundle: CPU address/strobes, peripheral
// request lines, the acknowledge from the CPU interrupt logic and the
// flag outputs. The bidirectional data bus DL is not carried here; it
// stays a plain inout on the register so tri-state resolution happens
// at an ordinary module port.
interface irq_flags_if #(
  parameter int NUM_SRC = 5
);
  logic [15:0]        A;
  logic               RD;
  logic               WR;
  logic [NUM_SRC-1:0] INT_REQ;
  logic [7:0]         CPU_IRQ_ACK;
  logic [7:0]         CPU_IRQ_TRIG;
  logic               IRQ_ANY;

  // CPU/peripheral side: drives strobes, requests and acks, sees flags
  modport master (
    output A, RD, WR, INT_REQ, CPU_IRQ_ACK,
    input  CPU_IRQ_TRIG, IRQ_ANY
  );

  // Register side
  modport slave (
    input  A, RD, WR, INT_REQ, CPU_IRQ_ACK,
    output CPU_IRQ_TRIG, IRQ_ANY
  );
endinterface

// File: rtl/irq_flags.sv
// Interrupt-flag register (IF). Captures rising edges on the peripheral
// request lines as sticky flags, clears a flag on the rising edge of its
// acknowledge, and exposes the flags to the CPU bus at IF_ADDR.
// NUM_SRC is legal from 1 to 8; unimplemented bits read back as 1 on the
// bus and are forced to 0 on CPU_IRQ_TRIG.
// Priority within one cycle: request edge > ack clear > bus write.
module irq_flags #(
  parameter int          NUM_SRC = 5,
  parameter logic [15:0] IF_ADDR = 16'hFF0F
) (
  input  logic       CLK,
  input  logic       RES,
  inout  wire  [7:0] DL,
  irq_flags_if.slave bus
);

  logic [NUM_SRC-1:0] r_flag;
  logic [NUM_SRC-1:0] r_req_q;
  logic [NUM_SRC-1:0] r_ack_q;
  logic               r_armed;

  logic               w_sel;
  logic               w_wr_en;
  logic               w_dl_oe;
  logic [NUM_SRC-1:0] w_ack_impl;
  logic [NUM_SRC-1:0] w_set_p;
  logic [NUM_SRC-1:0] w_clr_p;
  logic [NUM_SRC-1:0] w_base;
  logic [NUM_SRC-1:0] w_flag_next;
  logic [7:0]         w_rd_data;
  logic [7:0]         w_trig;
  logic               w_unused;

  assign w_sel      = (bus.A == IF_ADDR);
  assign w_wr_en    = bus.WR & w_sel;
  assign w_dl_oe    = bus.RD & w_sel;
  assign w_ack_impl = bus.CPU_IRQ_ACK[NUM_SRC-1:0];

  // r_armed is low for the first cycle after reset so a request that was
  // already high when reset released cannot look like a fresh edge.
  assign w_set_p = bus.INT_REQ & ~r_req_q & {NUM_SRC{r_armed}};
  assign w_clr_p = w_ack_impl & ~r_ack_q;

  // Bus write replaces the flags, ack edges clear, request edges win last
  assign w_base      = w_wr_en ? DL[NUM_SRC-1:0] : r_flag;
  assign w_flag_next = (w_base & ~w_clr_p) | w_set_p;

  // Read image: unimplemented upper bits read as 1
  always_comb begin
    w_rd_data              = 8'hFF;
    w_rd_data[NUM_SRC-1:0] = r_flag;
  end

  // Flag image to the CPU: unimplemented upper bits are 0
  always_comb begin
    w_trig              = 8'h00;
    w_trig[NUM_SRC-1:0] = r_flag;
  end

  assign DL               = w_dl_oe ? w_rd_data : 8'hzz;
  assign bus.CPU_IRQ_TRIG = w_trig;
  assign bus.IRQ_ANY      = |w_trig;

  // Upper ack bits and upper data-bus bits are intentionally ignored
  assign w_unused = &{1'b0, bus.CPU_IRQ_ACK, DL};

  // Sticky interrupt flags
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_flag <= '0;
    end else begin
      r_flag <= w_flag_next;
    end
  end

  // Previous request and ack levels for edge detection
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_req_q <= '0;
      r_ack_q <= '0;
    end else begin
      r_req_q <= bus.INT_REQ;
      r_ack_q <= w_ack_impl;
    end
  end

  // Edge detection becomes live one cycle after reset release
  always_ff @(posedge CLK or posedge RES) begin
    if (RES) begin
      r_armed <= 1'b0;
    end else begin
      r_armed <= 1'b1;
    end
  end

  // A simultaneous read and write of IF is a bus protocol error
  a_rd_wr_excl: assert property (@(posedge CLK) disable iff (RES)
    !(bus.RD && bus.WR && w_sel));

  // The interrupt logic acknowledges one source at a time
  a_ack_onehot: assert property (@(posedge CLK) disable iff (RES)
    $onehot0(bus.CPU_IRQ_ACK));

endmodule

// File: tb/tb_irq_flags.sv
// Directed bench for irq_flags: reset image, a vector table of
// single-cycle stimulus with hand-computed flags, then a mid-stream
// reset with a request held high across it.
module tb_irq_flags;

  logic       clk;
  logic       res;
  logic [7:0] tb_dl;
  logic       tb_dl_oe;
  wire  [7:0] dl;

  int total = 0;
  int bad   = 0;

  irq_flags_if #(.NUM_SRC(5)) bus ();

  irq_flags #(.NUM_SRC(5), .IF_ADDR(16'hFF0F)) dut (
    .CLK (clk),
    .RES (res),
    .DL  (dl),
    .bus (bus)
  );

  assign dl = tb_dl_oe ? tb_dl : 8'hzz;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic        rd;
    logic        wr;
    logic [7:0]  wdata;
    logic [4:0]  req;
    logic [7:0]  ack;
    logic [7:0]  trig;
    logic        any;
    logic [7:0]  dl;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic [15:0] a, input logic rd, input logic wr,
                         input logic [7:0] wdata, input logic [4:0] req,
                         input logic [7:0] ack, input logic [7:0] trig,
                         input logic any, input logic [7:0] dlx);
    vec_t v;
    v.a = a; v.rd = rd; v.wr = wr; v.wdata = wdata; v.req = req;
    v.ack = ack; v.trig = trig; v.any = any; v.dl = dlx;
    vecs.push_back(v);
  endtask

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    res             = 1'b1;
    tb_dl           = 8'h00;
    tb_dl_oe        = 1'b0;
    bus.A           = 16'h0000;
    bus.RD          = 1'b0;
    bus.WR          = 1'b0;
    bus.INT_REQ     = 5'h00;
    bus.CPU_IRQ_ACK = 8'h00;

    //       addr     rd wr wdata  req    ack    trig  any dl
    // Timer request held 3 cycles, then released; read back
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h04, 8'h00, 8'h04, 1, 8'h00);
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h04, 8'h00, 8'h04, 1, 8'h00);
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h04, 8'h00, 8'h04, 1, 8'h00);
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h00, 8'h00, 8'h04, 1, 8'h00);
    add_vec(16'hFF0F, 1, 0, 8'h00, 5'h00, 8'h00, 8'h04, 1, 8'hE4);
    // VBlank request -> flags 05
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h01, 8'h00, 8'h05, 1, 8'h00);
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h00, 8'h00, 8'h05, 1, 8'h00);
    // Ack bit 0 held 4 cycles clears once
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h00, 8'h01, 8'h04, 1, 8'h00);
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h00, 8'h01, 8'h04, 1, 8'h00);
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h00, 8'h01, 8'h04, 1, 8'h00);
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h00, 8'h01, 8'h04, 1, 8'h00);
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h00, 8'h00, 8'h04, 1, 8'h00);
    // Write 00 while request 0 rises: request wins
    add_vec(16'hFF0F, 0, 1, 8'h00, 5'h01, 8'h00, 8'h01, 1, 8'h00);
    add_vec(16'hFF0F, 1, 0, 8'h00, 5'h00, 8'h00, 8'h01, 1, 8'hE1);
    // Write 1F while ack 1 rises: ack wins
    add_vec(16'hFF0F, 0, 1, 8'h1F, 5'h00, 8'h02, 8'h1D, 1, 8'h00);
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h00, 8'h00, 8'h1D, 1, 8'h00);
    // Write FF, read next cycle, then write 00
    add_vec(16'hFF0F, 0, 1, 8'hFF, 5'h00, 8'h00, 8'h1F, 1, 8'h00);
    add_vec(16'hFF0F, 1, 0, 8'h00, 5'h00, 8'h00, 8'h1F, 1, 8'hFF);
    add_vec(16'hFF0F, 0, 1, 8'h00, 5'h00, 8'h00, 8'h00, 0, 8'h00);
    // Ack of an unimplemented bit is ignored
    add_vec(16'hFF0F, 0, 1, 8'h1F, 5'h00, 8'h00, 8'h1F, 1, 8'h00);
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h00, 8'h80, 8'h1F, 1, 8'h00);
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h00, 8'h00, 8'h1F, 1, 8'h00);
    // Other address: write ignored, read not driven
    add_vec(16'hFF0E, 0, 1, 8'h00, 5'h00, 8'h00, 8'h1F, 1, 8'h00);
    add_vec(16'hFF0E, 1, 0, 8'h00, 5'h00, 8'h00, 8'h1F, 1, 8'h00);
    add_vec(16'hFF0F, 0, 1, 8'h00, 5'h00, 8'h00, 8'h00, 0, 8'h00);
    // Request and ack rise together on bit 3: request wins; later ack clears
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h08, 8'h00, 8'h08, 1, 8'h00);
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h00, 8'h00, 8'h08, 1, 8'h00);
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h08, 8'h08, 8'h08, 1, 8'h00);
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h00, 8'h00, 8'h08, 1, 8'h00);
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h00, 8'h08, 8'h00, 0, 8'h00);
    add_vec(16'hFF0F, 0, 0, 8'h00, 5'h00, 8'h00, 8'h00, 0, 8'h00);

    // Reset image
    repeat (2) @(posedge clk);
    #1;
    chk8("reset_trig", bus.CPU_IRQ_TRIG, 8'h00);
    chk1("reset_any", bus.IRQ_ANY, 1'b0);
    chk1("reset_dl_oe", dut.w_dl_oe, 1'b0);
    res = 1'b0;
    tick();
    bus.A  = 16'hFF0F;
    bus.RD = 1'b1;
    #1;
    chk8("reset_read_dl", dl, 8'hE0);
    chk8("reset_read_trig", bus.CPU_IRQ_TRIG, 8'h00);

    foreach (vecs[i]) begin
      bus.A           = vecs[i].a;
      bus.RD          = vecs[i].rd;
      bus.WR          = vecs[i].wr;
      tb_dl           = vecs[i].wdata;
      tb_dl_oe        = vecs[i].wr;
      bus.INT_REQ     = vecs[i].req;
      bus.CPU_IRQ_ACK = vecs[i].ack;
      tick();
      chk8($sformatf("vec%0d_trig", i), bus.CPU_IRQ_TRIG, vecs[i].trig);
      chk1($sformatf("vec%0d_any", i), bus.IRQ_ANY, vecs[i].any);
      chk1($sformatf("vec%0d_dl_oe", i), dut.w_dl_oe,
           vecs[i].rd & (vecs[i].a == 16'hFF0F));
      if (vecs[i].rd)
        if (vecs[i].a == 16'hFF0F)
          chk8($sformatf("vec%0d_dl", i), dl, vecs[i].dl);
    end

    // Mid-stream reset with request 4 held high across it
    bus.A           = 16'hFF0F;
    bus.RD          = 1'b0;
    bus.WR          = 1'b0;
    tb_dl_oe        = 1'b0;
    bus.CPU_IRQ_ACK = 8'h00;
    bus.INT_REQ     = 5'h10;
    tick();
    chk8("rst_pre_trig", bus.CPU_IRQ_TRIG, 8'h10);
    #2;
    res = 1'b1;
    #1;
    chk8("rst_async_trig", bus.CPU_IRQ_TRIG, 8'h00);
    chk1("rst_async_any", bus.IRQ_ANY, 1'b0);
    @(posedge clk);
    #1;
    res = 1'b0;
    tick();
    chk8("rst_held_req_c1", bus.CPU_IRQ_TRIG, 8'h00);
    tick();
    chk8("rst_held_req_c2", bus.CPU_IRQ_TRIG, 8'h00);
    bus.INT_REQ = 5'h00;
    tick();
    chk8("rst_req_low", bus.CPU_IRQ_TRIG, 8'h00);
    bus.INT_REQ = 5'h10;
    tick();
    chk8("rst_req_rise_trig", bus.CPU_IRQ_TRIG, 8'h10);
    chk1("rst_req_rise_any", bus.IRQ_ANY, 1'b1);
    bus.RD = 1'b1;
    #1;
    chk8("rst_req_rise_dl", dl, 8'hF0);
    bus.RD = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
